// File: rtl/trap_ctrl.sv
// Trap and interrupt controller: pends/masks NUM_IRQ lines, arbitrates them against
// illegal-instruction faults, and issues a one-cycle redirect. Optional: TRAP_VECTORED_EN.
module trap_ctrl #(
  parameter int                 NUM_IRQ     = 8,
  parameter int                 CAUSE_WIDTH = 5,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
  parameter logic [31:0]        VECTOR_BASE = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_IRQ-1:0]     irq,
  input  logic                   invalid,
  input  logic                   mret,
  input  logic                   enable_we,
  input  logic [NUM_IRQ-1:0]     enable_wdata,
  output logic                   trap,
  output logic [31:0]            handler,
  output logic [CAUSE_WIDTH-1:0] cause,
  output logic [NUM_IRQ-1:0]     pending,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRAP    = 2'd1,
    S_HANDLER = 2'd2
  } state_e;

  localparam logic [CAUSE_WIDTH-1:0] CAUSE_ILLEGAL = '0;
  localparam logic [CAUSE_WIDTH-1:0] CAUSE_DFAULT  = '1;

  state_e                   state_q, state_d;
  logic [NUM_IRQ-1:0]       irq_q;
  logic [NUM_IRQ-1:0]       pend_q, pend_d;
  logic [NUM_IRQ-1:0]       enable_q, enable_d;
  logic                     trap_q, trap_d;
  logic                     busy_q, busy_d;
  logic [CAUSE_WIDTH-1:0]   cause_q, cause_d;
  logic [31:0]              handler_q, handler_d;

  logic [NUM_IRQ-1:0]       rise;
  logic [NUM_IRQ-1:0]       req;
  logic [NUM_IRQ-1:0]       grant;
  logic [NUM_IRQ-1:0]       clr;
  logic                     req_any;
  logic                     take_irq;

  // Lowest-index request wins; line i maps to cause i+1.
  function automatic logic [CAUSE_WIDTH-1:0] irq_cause(input logic [NUM_IRQ-1:0] r);
    irq_cause = CAUSE_ILLEGAL;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r[i]) irq_cause = CAUSE_WIDTH'(i + 1);
    end
  endfunction

  // Edge lines latch into pend_q; level lines are passed straight through.
  assign rise     = irq & ~irq_q & EDGE_MASK;
  assign pending  = (pend_q & EDGE_MASK) | (irq & ~EDGE_MASK);
  assign req      = pending & enable_q;
  assign req_any  = |req;
  assign grant    = req & (~req + NUM_IRQ'(1));
  assign take_irq = (state_q == S_IDLE) && !invalid && req_any;
  assign clr      = take_irq ? (grant & EDGE_MASK) : '0;
  assign pend_d   = (pend_q & ~clr) | rise;
  assign enable_d = enable_we ? enable_wdata : enable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (invalid || req_any) state_d = S_TRAP;
      end
      S_TRAP: begin
        state_d = S_HANDLER;
      end
      S_HANDLER: begin
        if (invalid)   state_d = S_TRAP;
        else if (mret) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A double-fault trap keeps busy high: the handler never really left.
  always_comb begin
    trap_d    = (state_d == S_TRAP);
    busy_d    = (state_d == S_HANDLER) ||
                ((state_d == S_TRAP) && (state_q == S_HANDLER));
    cause_d   = cause_q;
    handler_d = handler_q;
    if (state_d == S_TRAP) begin
      if (state_q == S_HANDLER) cause_d = CAUSE_DFAULT;
      else if (invalid)         cause_d = CAUSE_ILLEGAL;
      else                      cause_d = irq_cause(req);
`ifdef TRAP_VECTORED_EN
      handler_d = VECTOR_BASE + (32'(cause_d) << 2);
`else
      handler_d = VECTOR_BASE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= '0;
      pend_q    <= '0;
      enable_q  <= '0;
      trap_q    <= 1'b0;
      busy_q    <= 1'b0;
      cause_q   <= CAUSE_ILLEGAL;
      handler_q <= VECTOR_BASE;
    end else begin
      irq_q     <= irq;
      pend_q    <= pend_d;
      enable_q  <= enable_d;
      trap_q    <= trap_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
      handler_q <= handler_d;
    end
  end

  assign trap    = trap_q;
  assign busy    = busy_q;
  assign cause   = cause_q;
  assign handler = handler_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: 8 lines, lines 0-3 edge latched, lines 4-7 level.
module tb_trap_ctrl;

  localparam int          NUM_IRQ = 8;
  localparam int          CW      = 5;
  localparam logic [31:0] VB      = 32'h0000_4000;

  logic            clk;
  logic            rst;
  logic [7:0]      irq;
  logic            invalid;
  logic            mret;
  logic            enable_we;
  logic [7:0]      enable_wdata;
  logic            trap;
  logic [31:0]     handler;
  logic [CW-1:0]   cause;
  logic [7:0]      pending;
  logic            busy;

  int n_cmp = 0;
  int n_mis = 0;

  trap_ctrl #(
    .NUM_IRQ    (NUM_IRQ),
    .CAUSE_WIDTH(CW),
    .EDGE_MASK  (8'h0F),
    .VECTOR_BASE(VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq         (irq),
    .invalid     (invalid),
    .mret        (mret),
    .enable_we   (enable_we),
    .enable_wdata(enable_wdata),
    .trap        (trap),
    .handler     (handler),
    .cause       (cause),
    .pending     (pending),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_handler(input logic [31:0] c);
`ifdef TRAP_VECTORED_EN
    return VB + c * 32'd4;
`else
    return VB;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; irq = '0; invalid = 1'b0; mret = 1'b0;
    enable_we = 1'b0; enable_wdata = '0;
    tick(); tick();
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_handler", handler, VB);
    chk("rst_pending", 32'(pending), 32'd0);
    rst = 1'b0;

    // Illegal instruction from IDLE
    enable_we = 1'b1; enable_wdata = 8'hFF; tick();
    enable_we = 1'b0;
    invalid = 1'b1; tick();
    chk("ill_trap", 32'(trap), 32'd1);
    chk("ill_cause", 32'(cause), 32'd0);
    chk("ill_handler", handler, exp_handler(0));
    chk("ill_busy_trapcyc", 32'(busy), 32'd0);
    invalid = 1'b0; tick();
    chk("ill_trap_once", 32'(trap), 32'd0);
    chk("ill_busy", 32'(busy), 32'd1);

    // Lines 5 (level) and 2 (edge) rise together while the handler runs
    irq[5] = 1'b1; irq[2] = 1'b1; tick();
    chk("nest_pending", 32'(pending), 32'h24);
    irq[2] = 1'b0; tick();
    chk("nest_no_trap", 32'(trap), 32'd0);
    chk("nest_busy", 32'(busy), 32'd1);
    mret = 1'b1; tick();
    chk("mret_busy", 32'(busy), 32'd0);
    chk("mret_trap", 32'(trap), 32'd0);
    mret = 1'b0; tick();
    chk("prio_trap", 32'(trap), 32'd1);
    chk("prio_cause", 32'(cause), 32'd3);
    chk("prio_handler", handler, exp_handler(3));
    chk("prio_pend2_clr", 32'(pending), 32'h20);
    tick();
    chk("prio_busy", 32'(busy), 32'd1);
    mret = 1'b1; tick();
    mret = 1'b0; tick();
    chk("lvl_trap", 32'(trap), 32'd1);
    chk("lvl_cause", 32'(cause), 32'd6);
    tick();
    irq[5] = 1'b0; mret = 1'b1; tick();
    mret = 1'b0; tick();
    chk("lvl_gone_trap", 32'(trap), 32'd0);
    chk("cause_hold", 32'(cause), 32'd6);
    chk("lvl_gone_busy", 32'(busy), 32'd0);

    // Masked edge, then unmask
    enable_we = 1'b1; enable_wdata = 8'h00; tick();
    enable_we = 1'b0; irq[0] = 1'b1; tick();
    chk("mask_pending", 32'(pending), 32'h01);
    chk("mask_no_trap", 32'(trap), 32'd0);
    irq[0] = 1'b0; tick(); tick();
    chk("mask_still_no_trap", 32'(trap), 32'd0);
    chk("mask_pending_held", 32'(pending), 32'h01);
    enable_we = 1'b1; enable_wdata = 8'h01; tick();
    chk("unmask_trap_early", 32'(trap), 32'd0);
    enable_we = 1'b0; tick();
    chk("unmask_trap", 32'(trap), 32'd1);
    chk("unmask_cause", 32'(cause), 32'd1);
    chk("unmask_pend_clr", 32'(pending), 32'h00);
    tick();
    chk("unmask_busy", 32'(busy), 32'd1);

    // Double fault: invalid and mret together in HANDLER
    invalid = 1'b1; mret = 1'b1; tick();
    chk("df_trap", 32'(trap), 32'd1);
    chk("df_cause", 32'(cause), 32'h1F);
    chk("df_busy", 32'(busy), 32'd1);
    chk("df_handler", handler, exp_handler(32'h1F));
    invalid = 1'b0; mret = 1'b0; tick();
    chk("df_trap_once", 32'(trap), 32'd0);
    chk("df_busy_after", 32'(busy), 32'd1);

    // Reset mid-handler with a latched edge
    irq[0] = 1'b1; tick();
    irq[0] = 1'b0; tick();
    chk("pre_rst_pending", 32'(pending), 32'h01);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("mid_rst_trap", 32'(trap), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cause", 32'(cause), 32'd0);
    chk("mid_rst_handler", handler, VB);
    chk("mid_rst_pending", 32'(pending), 32'h00);
    enable_we = 1'b1; enable_wdata = 8'hFF; tick();
    enable_we = 1'b0; tick(); tick();
    chk("post_rst_no_trap", 32'(trap), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // New edge on line 3 after reset
    irq[3] = 1'b1; tick();
    chk("irq3_pending", 32'(pending), 32'h08);
    chk("irq3_no_trap_yet", 32'(trap), 32'd0);
    irq[3] = 1'b0; tick();
    chk("irq3_trap", 32'(trap), 32'd1);
    chk("irq3_cause", 32'(cause), 32'd4);
    chk("irq3_handler", handler, exp_handler(4));
    tick();
    chk("irq3_busy", 32'(busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Parametrised trap and interrupt controller that replaces the single-line `irq | invalid` trap generation in the core. It latches or samples `NUM_IRQ` interrupt lines, masks them, and arbitrates them by fixed priority against the decode-stage illegal-instruction exception. It drives a one-cycle `trap` pulse with cause code and handler address into fetch. It tracks handler occupancy until `mret`, and escalates a fault taken inside a handler to a double fault.

## Interface
- `NUM_IRQ`, 8, number of external interrupt lines (1..29)
- `CAUSE_WIDTH`, 5, cause code width; `2**CAUSE_WIDTH >= NUM_IRQ + 2` is required
- `EDGE_MASK`, '0 (NUM_IRQ bits), bit i = 1 makes line i rising-edge latched; bit i = 0 makes it level sensitive
- `VECTOR_BASE`, core::KERN_BASE, 32-bit handler base address
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `irq`  in  NUM_IRQ  external interrupt lines
- `invalid`  in  1  illegal-instruction flag from decode
- `mret`  in  1  return-from-trap pulse from execute
- `enable_we`  in  1  interrupt-enable register write strobe
- `enable_wdata`  in  NUM_IRQ  new enable mask
- `trap`  out  1  one-cycle redirect request to fetch
- `handler`  out  32  redirect target, valid while `trap` = 1
- `cause`  out  CAUSE_WIDTH  code of the most recently taken trap
- `pending`  out  NUM_IRQ  raw pending lines (unmasked)
- `busy`  out  1  a handler is executing

## Operation
- Cause codes:
  - 0 = illegal instruction
  - 1+i = interrupt line i
  - all ones = double fault
- Pending logic:
  - Edge lines set `pend[i]` when `irq[i]` = 1 and `irq_q[i]` = 0, where `irq_q` is the line registered one cycle earlier.
  - Edge lines clear `pend[i]` in the cycle the trap for line i is issued. If a set and a clear hit the same line in the same cycle, set wins.
  - Level lines: `pending[i]` = `irq[i]` directly. The source is responsible for deasserting the line.
- Request: `req` = `pending & enable`. `enable` is written from `enable_wdata` when `enable_we` = 1.
- Priority: `invalid` first, then the lowest-index set bit of `req`.
- States:
  - IDLE: if `invalid` → TRAP with cause 0. Else if `req` != 0 → TRAP with cause 1+i. Else stay in IDLE. `mret` is ignored.
  - TRAP: held for exactly one cycle. `trap` = 1. Goes to HANDLER. `mret` and `invalid` are ignored.
  - HANDLER: `busy` = 1 and interrupts are not taken (no nesting). If `invalid` → TRAP with the double-fault cause; if `mret` is also asserted that cycle, it is ignored. Else if `mret` → IDLE. Else stay in HANDLER.
- Handler address: defined under Configuration.
- Reset values:
  - `trap` = 0, `busy` = 0, `cause` = 0, `handler` = VECTOR_BASE
  - `enable` = 0 (all lines masked), `pend` = 0, `irq_q` = 0
  - state = IDLE
  - Because `irq_q` resets to 0, an edge line that is already high when reset deasserts registers an edge in the first cycle after reset.
- Reset mid-handler returns to IDLE and discards all latched pending bits.

## Timing
- All outputs are registered except `pending`, which is combinational from `pend` and `irq`.
- Trap latency: a condition present in cycle N while in IDLE produces `trap` = 1 with valid `cause`/`handler` in cycle N+1, and `busy` = 1 from cycle N+2.
- An edge on `irq` in cycle N becomes visible in `pend` in cycle N+1, so the earliest resulting trap is in cycle N+2.
- `mret` in cycle M while in HANDLER: `busy` = 0 in M+1. A request that is already pending traps in M+2.
- An `enable_we` write in cycle N first affects arbitration in cycle N+1.
- `cause` holds its value until the next trap.

## Configuration
- `TRAP_VECTORED_EN` defined: `handler` = VECTOR_BASE + (`cause` << 2).
- Undefined: `handler` = VECTOR_BASE for every cause, and software reads `cause`.

## Test plan
- Reset, then set `enable` = 8'hFF and pulse `invalid` for 1 cycle → `trap` = 1 for exactly 1 cycle, `cause` = 0, `busy` = 1 the following cycle.
- EDGE_MASK = 8'h0F: raise `irq[5]` and `irq[2]` in the same cycle → first trap has `cause` = 3. After `mret`, the second trap has `cause` = 6 only while `irq[5]` is still high; `pend[2]` clears in the trap cycle.
- `enable` = 0 with `irq[0]` edge → `pending[0]` = 1 and no trap. Then write `enable` = 1 → `trap` two cycles after the write strobe, `cause` = 1.
- In HANDLER, assert `invalid` and `mret` together → `trap` = 1 with `cause` = 5'h1F, and `busy` stays 1.
- Assert `rst` one cycle while in HANDLER with `pend` = 8'h01 → all outputs at reset values and no trap until a new edge arrives.
- Build with `TRAP_VECTORED_EN`, take `irq[3]` → `handler` = VECTOR_BASE + 16. Build without it → `handler` = VECTOR_BASE.
